// File: rtl/cr_kme_ckv_responder.sv
// CKV SRAM responder: pipeline reads own the SRAM with fixed latency 2, a single
// outstanding host access fills idle slots, and pipeline MBEs are counted and captured.
module cr_kme_ckv_responder #(
  parameter int CKV_AW       = 15,
  parameter int CKV_DW       = 64,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ckv_rd,
  input  logic [CKV_AW-1:0] ckv_addr,
  output logic [CKV_DW-1:0] ckv_dout,
  output logic              ckv_mbe,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [CKV_AW-1:0] host_addr,
  input  logic [CKV_DW-1:0] host_wdata,
  output logic              host_busy,
  output logic              host_ack,
  output logic [CKV_DW-1:0] host_rdata,
  output logic              host_mbe,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [CKV_AW-1:0] sram_addr,
  output logic [CKV_DW-1:0] sram_wdata,
  input  logic [CKV_DW-1:0] sram_rdata,
  input  logic              sram_mbe,
  input  logic              mbe_clr,
  output logic              stat_ckv_mbe,
  output logic [15:0]       mbe_count,
  output logic [CKV_AW-1:0] mbe_addr,
  output logic              mbe_addr_valid,
  output logic              host_starved
);

  localparam int WCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_LIMIT);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, PEND, WAIT, DONE} host_state_t;

  host_state_t       state;
  logic              lat_wr;
  logic [CKV_AW-1:0] lat_addr;
  logic [CKV_DW-1:0] lat_wdata;
  logic [WCW-1:0]    wait_cnt;
  logic              rd_d1;
  logic [CKV_AW-1:0] addr_d1;
  logic              host_issue;
  logic              new_mbe;

  // The host only gets the SRAM in a slot the pipeline leaves empty; a transaction
  // caught by reset must not touch the SRAM.
  assign host_issue = (state == PEND) && !ckv_rd && !rst;
  assign sram_cs    = ckv_rd || host_issue;
  assign sram_we    = host_issue && lat_wr;
  assign sram_addr  = ckv_rd ? ckv_addr : lat_addr;
  assign sram_wdata = lat_wdata;
  assign new_mbe    = rd_d1 && sram_mbe;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d1          <= 1'b0;
      addr_d1        <= '0;
      ckv_dout       <= '0;
      ckv_mbe        <= 1'b0;
      stat_ckv_mbe   <= 1'b0;
      mbe_count      <= '0;
      mbe_addr       <= '0;
      mbe_addr_valid <= 1'b0;
    end else begin
      rd_d1        <= ckv_rd;
      addr_d1      <= ckv_addr;
      stat_ckv_mbe <= new_mbe;
      if (rd_d1) begin
        ckv_dout <= sram_rdata;
        ckv_mbe  <= sram_mbe;
      end
      // A new MBE arriving together with mbe_clr restarts the statistics from it.
      if (new_mbe) begin
        if (mbe_clr)
          mbe_count <= 16'd1;
        else if (mbe_count != CNT_MAX)
          mbe_count <= mbe_count + 16'd1;
        if (mbe_clr || !mbe_addr_valid) begin
          mbe_addr       <= addr_d1;
          mbe_addr_valid <= 1'b1;
        end
      end else if (mbe_clr) begin
        mbe_count      <= '0;
        mbe_addr_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_wr       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      wait_cnt     <= '0;
      host_busy    <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      host_mbe     <= 1'b0;
      host_starved <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      if (mbe_clr)
        host_starved <= 1'b0;
      case (state)
        IDLE: begin
          if (host_req) begin
            lat_wr    <= host_wr;
            lat_addr  <= host_addr;
            lat_wdata <= host_wdata;
            host_busy <= 1'b1;
            state     <= PEND;
          end
        end
        PEND: begin
          if (wait_cnt == WAIT_MAX)
            host_starved <= 1'b1;
          if (ckv_rd) begin
            if (wait_cnt != WAIT_MAX)
              wait_cnt <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!lat_wr) begin
            host_rdata <= sram_rdata;
            host_mbe   <= sram_mbe;
          end
          host_ack <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          host_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
